// File: rtl/round_sequencer.sv
// round_sequencer
// Sequences the five datapath stages of one permutation round in the fixed
// order CP, RO, PE, RE, RC, repeated for NUM_ROUNDS rounds. Each stage gets a
// one-cycle start pulse in its GO state. The sequencer then sits in the
// stage's WAIT state until that stage's finish arrives.
// All outputs are decoded from the state register only, so there is no
// combinational path from any input to any output.
// Optional per-stage watchdog: define ROUND_SEQUENCER_TIMEOUT_EN.
module round_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       CP_start,
  output logic       RO_start,
  output logic       PE_start,
  output logic       RE_start,
  output logic       RC_start,
  input  logic       CP_finish,
  input  logic       RO_finish,
  input  logic       PE_finish,
  input  logic       RE_finish,
  input  logic       RC_finish,
  output logic [5:0] iteration,
  output logic       busy,
  output logic       finish,
  output logic       error
);

  typedef enum logic [3:0] {
    IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT,
    RE_GO, RE_WAIT, RC_GO, RC_WAIT, DONE, ERROR
  } state_e;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  // Reject out-of-range parameters at elaboration time.
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 63 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("round_sequencer: NUM_ROUNDS or TIMEOUT_CYCLES out of range");
  end

  state_e     state_q, state_d;
  logic [5:0] iteration_q, iteration_d;
  logic       stage_done;

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wd_q, wd_d;
  logic       in_go;
  logic       in_wait;

  assign in_go   = state_q inside {CP_GO, RO_GO, PE_GO, RE_GO, RC_GO};
  assign in_wait = state_q inside {CP_WAIT, RO_WAIT, PE_WAIT, RE_WAIT, RC_WAIT};
`endif

  // A WAIT state completes only on the finish of its own stage.
  // Finishes from other stages, or arriving during GO, are ignored.
  always_comb begin
    stage_done = 1'b0;
    unique case (state_q)
      CP_WAIT: stage_done = CP_finish;
      RO_WAIT: stage_done = RO_finish;
      PE_WAIT: stage_done = PE_finish;
      RE_WAIT: stage_done = RE_finish;
      RC_WAIT: stage_done = RC_finish;
      default: stage_done = 1'b0;
    endcase
  end

  // Compute the next state, round index and watchdog count.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    iteration_d = iteration_q;
    unique case (state_q)
      IDLE, ERROR: begin
        // start is only looked at while not busy; a run is never queued.
        if (start) begin
          state_d     = CP_GO;
          iteration_d = '0;
        end
      end
      CP_GO:   state_d = CP_WAIT;
      CP_WAIT: if (stage_done) state_d = RO_GO;
      RO_GO:   state_d = RO_WAIT;
      RO_WAIT: if (stage_done) state_d = PE_GO;
      PE_GO:   state_d = PE_WAIT;
      PE_WAIT: if (stage_done) state_d = RE_GO;
      RE_GO:   state_d = RE_WAIT;
      RE_WAIT: if (stage_done) state_d = RC_GO;
      RC_GO:   state_d = RC_WAIT;
      RC_WAIT: begin
        if (stage_done) begin
          if (iteration_q < LAST_ROUND) begin
            iteration_d = iteration_q + 6'd1;
            state_d     = CP_GO;
          end else begin
            // The last round leaves iteration unchanged through DONE.
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        iteration_d = '0;
      end
      default: state_d = IDLE;
    endcase

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
    // The watchdog counts WAIT cycles that lack the matching finish.
    // It is cleared in every GO state.
    wd_d = wd_q;
    if (in_go) begin
      wd_d = '0;
    end else if (in_wait && !stage_done) begin
      wd_d = wd_q + 8'd1;
      if (wd_d == TIMEOUT_LIMIT) state_d = ERROR;
    end
`endif
  end

  // Hold the state, round index and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      iteration_q <= '0;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      iteration_q <= iteration_d;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign CP_start  = (state_q == CP_GO);
  assign RO_start  = (state_q == RO_GO);
  assign PE_start  = (state_q == PE_GO);
  assign RE_start  = (state_q == RE_GO);
  assign RC_start  = (state_q == RC_GO);
  assign iteration = iteration_q;
  assign busy      = (state_q != IDLE) && (state_q != ERROR);
  assign finish    = (state_q == DONE);

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  assign error = (state_q == ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer.
// Instance dut_a uses 24 rounds and a watchdog limit of 4.
// Instance dut_b uses a single round.
// A stage-level model of dut_a is compared on every cycle.
// Directed runs pin cycle counts and pulse counts with literal values.
`timescale 1ns/1ps
module tb_round_sequencer;

  localparam int N_A = 24;
  localparam int T_A = 4;
  localparam int N_B = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_start = 1'b0;
  logic [4:0] a_fin = '0;
  logic [4:0] a_go;
  logic [5:0] a_iter;
  logic       a_busy, a_finish, a_error;
  logic       b_start = 1'b0;
  logic [4:0] b_fin = '0;
  logic [4:0] b_go;
  logic [5:0] b_iter;
  logic       b_busy, b_finish, b_error;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Responder configuration for dut_a.
  int delay_cfg      = 0;
  int pend_stage     = -1;
  int pend_cnt       = 0;
  int withhold_round = -1;
  int cyc            = 0;

  always #5 clk = ~clk;

  round_sequencer #(.NUM_ROUNDS(N_A), .TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .CP_start(a_go[0]), .RO_start(a_go[1]), .PE_start(a_go[2]),
    .RE_start(a_go[3]), .RC_start(a_go[4]),
    .CP_finish(a_fin[0]), .RO_finish(a_fin[1]), .PE_finish(a_fin[2]),
    .RE_finish(a_fin[3]), .RC_finish(a_fin[4]),
    .iteration(a_iter), .busy(a_busy), .finish(a_finish), .error(a_error)
  );

  round_sequencer #(.NUM_ROUNDS(N_B), .TIMEOUT_CYCLES(T_A)) dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .CP_start(b_go[0]), .RO_start(b_go[1]), .PE_start(b_go[2]),
    .RE_start(b_go[3]), .RC_start(b_go[4]),
    .CP_finish(b_fin[0]), .RO_finish(b_fin[1]), .PE_finish(b_fin[2]),
    .RE_finish(b_fin[3]), .RC_finish(b_fin[4]),
    .iteration(b_iter), .busy(b_busy), .finish(b_finish), .error(b_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stage-level model of dut_a. It tracks whether a run is active, which stage
  // (0..4) is current, whether this is the stage's launch cycle, and the round.
  bit m_active, m_go, m_done, m_err;
  int m_stage, m_round, m_wait;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_go = 0; m_done = 0; m_err = 0;
      m_stage = 0; m_round = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0; m_round = 0;
    end else if (!m_active) begin
      if (a_start) begin
        m_active = 1; m_go = 1; m_stage = 0; m_round = 0; m_err = 0;
      end
    end else if (m_go) begin
      m_go = 0; m_wait = 0;
    end else if (a_fin[m_stage]) begin
      if (m_stage < 4) begin
        m_stage++; m_go = 1;
      end else if (m_round < N_A - 1) begin
        m_round++; m_stage = 0; m_go = 1;
      end else begin
        m_active = 0; m_done = 1;
      end
    end
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
    else begin
      m_wait++;
      if (m_wait == T_A) begin
        m_active = 0; m_err = 1;
      end
    end
`endif
  end

  // Compare dut_a against the model every cycle, away from the clock edge.
  logic [4:0] e_go;
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      e_go = (m_active && m_go) ? 5'(1 << m_stage) : 5'd0;
      check("cmp_starts", 64'(a_go), 64'(e_go));
      check("cmp_iteration", 64'(a_iter), 64'(m_round));
      check("cmp_busy", 64'(a_busy), 64'(m_active || m_done));
      check("cmp_finish", 64'(a_finish), 64'(m_done));
      check("cmp_error", 64'(a_error), 64'(m_err));
    end
  end

  // Advance to the next negedge and drive the dut_a finish responder.
  task automatic tick();
    @(negedge clk);
    cyc++;
    a_fin = '0;
    if (pend_stage >= 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        a_fin[pend_stage] = 1'b1;
        pend_stage = -1;
      end
    end
    for (int s = 0; s < 5; s++) begin
      if (a_go[s] && !(s == 3 && int'(a_iter) == withhold_round)) begin
        pend_stage = s;
        pend_cnt   = delay_cfg + 1;
      end
    end
  endtask

  // One dut_a run. Call it at a negedge.
  // start_at: cycle to pulse start again (0 means never).
  // rst_at: cycle to assert reset and abort (0 means never).
  task automatic run_a(input int delay, input int limit, input int start_at,
                       input int rst_at, input bit spur, output int fin_cyc);
    int pulses[5] = '{default: 0};
    int exp_stage = 0;
    int exp_round = 0;
    int order_err = 0;
    int first_ro  = 0;
    delay_cfg  = delay;
    pend_stage = -1;
    fin_cyc    = 0;
    a_start    = 1'b1;
    cyc        = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      a_start = 1'b0;
      for (int s = 0; s < 5; s++) begin
        if (a_go[s]) begin
          pulses[s]++;
          if (s != exp_stage || int'(a_iter) != exp_round) order_err++;
          if (s == 1 && first_ro == 0) first_ro = cyc;
          exp_stage = (s == 4) ? 0 : s + 1;
          if (s == 4) exp_round++;
        end
      end
      if (spur && cyc == 1) a_fin[0] = 1'b1;   // CP_finish during CP_GO
      if (spur && cyc == 2) a_fin[1] = 1'b1;   // RO_finish during CP_WAIT
      if (spur && cyc == 3) check("spur_no_stage_start", 64'(a_go), 64'd0);
      if (start_at != 0 && cyc == start_at + 1) check("busy_start_ignored_cp", 64'(a_go[0]), 64'd0);
      if (cyc == start_at) a_start = 1'b1;
      if (cyc == rst_at) begin
        check("pre_rst_busy", 64'(a_busy), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_async_starts", 64'(a_go), 64'd0);
        check("rst_async_busy", 64'(a_busy), 64'd0);
        check("rst_async_iter", 64'(a_iter), 64'd0);
        check("rst_async_finish", 64'(a_finish), 64'd0);
        pend_stage = -1;
        a_fin = '0;
        break;
      end
      if (a_finish) begin
        fin_cyc = cyc;
        break;
      end
    end
    check("order_and_iteration", 64'(order_err), 64'd0);
    if (first_ro != 0) check("first_ro_cycle", 64'(first_ro), 64'(delay + 3));
    if (fin_cyc != 0) begin
      for (int s = 0; s < 5; s++) check("stage_pulse_count", 64'(pulses[s]), 64'(N_A));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int fc;
    int bc, bfin, pcnt, iter_bad, bpend;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_starts", 64'(a_go), 64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    check("reset_finish", 64'(a_finish), 64'd0);
    check("reset_error", 64'(a_error), 64'd0);
    check("reset_iter", 64'(a_iter), 64'd0);
    check("reset_b_busy", 64'(b_busy), 64'd0);
    rst = 1'b1;
    tick(); tick();
    check("idle_without_start", 64'(a_busy), 64'd0);

    // Full run with every finish returned on the first WAIT cycle.
    run_a(0, 300, 0, 0, 1'b0, fc);
    check("finish_cycle_prompt", 64'(fc), 64'd241);
    tick();
    check("busy_low_242", 64'(a_busy), 64'd0);
    check("iter_cleared_after_done", 64'(a_iter), 64'd0);

    // Finish 3 cycles late, with stray finishes in round 0.
    tick();
    run_a(3, 700, 0, 0, 1'b1, fc);
    check("finish_cycle_late", 64'(fc), 64'd601);
    tick();
    check("busy_low_after_late", 64'(a_busy), 64'd0);

    // Start while busy (round 5 PE_WAIT), then reset in round 10 RE_WAIT.
    tick();
    run_a(0, 300, 56, 108, 1'b0, fc);
    check("aborted_run_no_finish", 64'(fc), 64'd0);
    repeat (2) @(negedge clk);
    check("in_reset_busy", 64'(a_busy), 64'd0);
    rst = 1'b1;
    repeat (3) tick();
    check("no_resume_after_reset", 64'(a_busy), 64'd0);
    run_a(0, 300, 0, 0, 1'b0, fc);
    check("finish_cycle_restart", 64'(fc), 64'd241);
    tick();

    // Single-round instance.
    b_start = 1'b1; bc = 0; bfin = 0; pcnt = 0; iter_bad = 0; bpend = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bc++;
      b_start = 1'b0;
      b_fin = '0;
      if (bpend >= 0) begin
        b_fin[bpend] = 1'b1;
        bpend = -1;
      end
      for (int s = 0; s < 5; s++) if (b_go[s]) begin pcnt++; bpend = s; end
      if (b_iter != 6'd0) iter_bad++;
      if (b_finish) begin bfin = bc; break; end
    end
    check("b_finish_cycle", 64'(bfin), 64'd11);
    check("b_start_pulses", 64'(pcnt), 64'd5);
    check("b_iter_zero", 64'(iter_bad), 64'd0);
    @(negedge clk);
    check("b_busy_after", 64'(b_busy), 64'd0);

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
    // Withhold RE_finish in round 2; RE_WAIT spans cycles 28..31, so ERROR is at 32.
    tick();
    withhold_round = 2;
    run_a(0, 32, 0, 0, 1'b0, fc);
    check("wd_error_set", 64'(a_error), 64'd1);
    check("wd_busy_low", 64'(a_busy), 64'd0);
    check("wd_no_finish", 64'(fc), 64'd0);
    withhold_round = -1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("wd_restart_error", 64'(a_error), 64'd0);
    check("wd_restart_cp", 64'(a_go), 64'd1);
    check("wd_restart_iter", 64'(a_iter), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 24: permutation rounds per run, legal range 1..63.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit per stage wait, legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE or ERROR.
REQ-006 SHALL have ports CP_start, RO_start, PE_start, RE_start, RC_start  output  1 each  one-cycle stage start pulses to the datapath.
REQ-007 SHALL have ports CP_finish, RO_finish, PE_finish, RE_finish, RC_finish  input  1 each  stage completion from the datapath.
REQ-008 SHALL have port iteration  output  6  current round index to the datapath.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE and ERROR.
REQ-010 SHALL have port finish  output  1  one-cycle pulse at the end of a successful run.
REQ-011 SHALL have port error  output  1  stage timeout flag; tied 0 when the watchdog is compiled out.

Function
REQ-012 SHALL implement the states IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT, RE_GO, RE_WAIT, RC_GO, RC_WAIT, DONE and ERROR.
REQ-013 SHALL move from IDLE to CP_GO on start=1 and clear iteration to 0.
REQ-014 SHALL assert X_start only during X_GO (exactly one cycle) and go unconditionally from X_GO to X_WAIT.
REQ-015 SHALL leave X_WAIT on X_finish=1 and advance in the order CP, RO, PE, RE, RC.
REQ-016 SHALL ignore X_finish while in X_GO, and ignore any finish input that does not belong to the current WAIT state.
REQ-017 SHALL, on RC_finish in RC_WAIT, increment iteration and go to CP_GO if iteration < NUM_ROUNDS-1, otherwise go to DONE with iteration unchanged.
REQ-018 SHALL assert finish for exactly the one cycle spent in DONE, then return to IDLE with iteration cleared to 0.
REQ-019 SHALL ignore start whenever busy=1; a run is never restarted or queued.
REQ-020 SHALL take 2 cycles per stage when finish arrives on the first WAIT cycle: CP_start in cycle 1 after the start edge, round r CP_start in cycle 1+10r, and finish in cycle 10*NUM_ROUNDS+1.
REQ-021 SHALL drive all outputs from registered state, with no combinational path from any input to any output.

Reset
REQ-022 SHALL, on rst=0, enter IDLE immediately and asynchronously, regardless of the current state or any in-flight stage.
REQ-023 SHALL hold all start outputs, busy, finish and error at 0, iteration at 0, and the watchdog count at 0 while in reset.
REQ-024 SHALL require a new start after reset release; an interrupted run is not resumed.

Configuration
REQ-025 SHALL compile a per-stage watchdog in when macro ROUND_SEQUENCER_TIMEOUT_EN is defined: an 8-bit counter clears in each GO state and increments each WAIT cycle without the matching finish.
REQ-026 SHALL, with the macro defined, go to ERROR and set error=1 when the watchdog count reaches TIMEOUT_CYCLES.
REQ-027 SHALL hold error=1 in ERROR until reset or start; start in ERROR clears error, clears iteration and enters CP_GO.
REQ-028 SHALL, with the macro undefined, wait indefinitely in WAIT states, never reach ERROR, and tie error to 0.

Verification
REQ-029 SHALL cover: NUM_ROUNDS=24 with every finish returned on the first WAIT cycle -> 24 pulses on each X_start, iteration 0..23, finish at cycle 241, busy low at cycle 242.
REQ-030 SHALL cover: finish returned 3 cycles late on every stage -> order still CP,RO,PE,RE,RC per round and finish at cycle 24*(5*5)+1 = 601.
REQ-031 SHALL cover: RO_finish pulsed during CP_WAIT, and CP_finish pulsed during CP_GO -> both ignored, state stays CP_WAIT, no RO_start.
REQ-032 SHALL cover: start pulsed at round 5 during PE_WAIT -> no effect; rst=0 during round 10 RE_WAIT -> all outputs 0 immediately, restart runs from iteration 0.
REQ-033 SHALL cover: macro defined, TIMEOUT_CYCLES=4, RE_finish withheld in round 2 -> ERROR after 4 wait cycles, error=1 and busy=0; then start -> error=0, CP_start with iteration=0.
REQ-034 SHALL cover: NUM_ROUNDS=1 -> one round of 5 start pulses, finish at cycle 11, iteration=0 throughout.
